// File: rtl/cfg_reg_arbiter.sv
// ---------------------------------------------------------------------------
// cfg_reg_arbiter
//
// Purpose:
//   Shares one single-port config/status register bank between two
//   requesters (req 0 = SPI slave register path, req 1 = local engine).
//   Exactly one access is in flight at a time and follows the sequence
//   IDLE (accept) -> ACCESS (bank strobe) -> RESP (completion pulse).
//   Requesters are arbitrated round-robin. A requester can ask to keep
//   the grant for its next access (lock). While the other requester is
//   waiting, a lock can hold the grant for at most MAX_BURST consecutive
//   grants.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   req_valid[1:0] per-requester request, held until req_ready
//   req_write[1:0] 1 = write, 0 = read
//   req_lock[1:0]  ask to keep the grant for the next access
//   req_addr       two packed ADDR_WIDTH addresses, requester i at [i*AW +: AW]
//   req_wdata      two packed REG_WIDTH write data words
//   req_ready[1:0] one-cycle accept pulse to the winning requester
//   rsp_valid[1:0] one-cycle completion pulse to the owner, 2 cycles after accept
//   rsp_rdata      read data (0 for writes, errors and when rsp_valid is 0)
//   rsp_err        address out of range, valid with rsp_valid
//   bank_en/we     bank access strobe and write enable
//   bank_addr      bank address
//   bank_wdata     bank write data
//   bank_rdata     bank read data, valid the cycle after bank_en
// ---------------------------------------------------------------------------
module cfg_reg_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int REG_WIDTH  = 8,
    parameter int NUM_REGS   = 64,
    parameter int MAX_BURST  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [1:0]              req_lock,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*REG_WIDTH-1:0]  req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [REG_WIDTH-1:0]    rsp_rdata,
    output logic                    rsp_err,
    output logic                    bank_en,
    output logic                    bank_we,
    output logic [ADDR_WIDTH-1:0]   bank_addr,
    output logic [REG_WIDTH-1:0]    bank_wdata,
    input  logic [REG_WIDTH-1:0]    bank_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Registered state
    state_t                  state_q,     state_d;
    logic                    rr_ptr_q,    rr_ptr_d;
    logic                    owner_q,     owner_d;
    logic                    lock_q,      lock_d;
    logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic                    write_q,     write_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [REG_WIDTH-1:0]    wdata_q,     wdata_d;
    logic                    err_q,       err_d;

    // Per-requester views of the packed request buses
    logic [ADDR_WIDTH-1:0]   addr_arr  [2];
    logic [REG_WIDTH-1:0]    wdata_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*REG_WIDTH +: REG_WIDTH];
        end
    endgenerate

    // Arbitration signals
    logic grant;
    logic winner;
    logic held;        // grant kept by the previous owner's lock
    logic other_idx;
    logic lock_hold;
    logic burst_full;
    logic in_range;

    assign in_range = int'(addr_q) < NUM_REGS;

    // -----------------------------------------------------------------------
    // Winner selection, evaluated every cycle but only acted on in IDLE.
    // The lock only counts while its owner is still requesting; dropping
    // req_valid releases it. Once the owner has held the grant for
    // MAX_BURST consecutive grants with the other side waiting, the lock
    // is overridden and the other requester wins.
    // -----------------------------------------------------------------------
    always_comb begin
        winner     = 1'b0;
        held       = 1'b0;
        other_idx  = ~owner_q;
        lock_hold  = lock_q & req_valid[owner_q];
        burst_full = (int'(burst_cnt_q) + 1) >= MAX_BURST;
        grant      = |req_valid;

        if (lock_hold && !(req_valid[other_idx] && burst_full)) begin
            winner = owner_q;
            held   = 1'b1;
        end else if (lock_hold) begin
            winner = other_idx;
        end else if (&req_valid) begin
            winner = rr_ptr_q;
        end else begin
            winner = req_valid[1];
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 1'b0;
            owner_q     <= 1'b0;
            lock_q      <= 1'b0;
            burst_cnt_q <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            lock_q      <= lock_d;
            burst_cnt_q <= burst_cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        lock_d      = lock_q;
        burst_cnt_d = burst_cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_ACCESS;
                    owner_d = winner;
                    lock_d  = req_lock[winner];
                    write_d = req_write[winner];
                    addr_d  = addr_arr[winner];
                    wdata_d = wdata_arr[winner];
                    // A lock-held grant leaves the round-robin pointer alone
                    rr_ptr_d = held ? rr_ptr_q : ~winner;
                    // Only locked grants made while the other side waits
                    // extend the burst; anything else starts over.
                    if (held && req_valid[~winner]) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end else begin
                        burst_cnt_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                err_d   = ~in_range;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // req_ready is combinational from req_valid so the accept lands in the
    // same cycle the request is seen; it is masked by rst so that every
    // output reads 0 while reset is held.
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        bank_en    = 1'b0;
        bank_we    = 1'b0;
        bank_addr  = '0;
        bank_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant && !rst) begin
                    req_ready[winner] = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (in_range) begin
                    bank_en    = 1'b1;
                    bank_we    = write_q;
                    bank_addr  = addr_q;
                    bank_wdata = write_q ? wdata_q : '0;
                end
            end
            ST_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                rsp_err            = err_q;
                if (!write_q && !err_q) begin
                    rsp_rdata = bank_rdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
module tb_cfg_reg_arbiter;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int NREGS = 60;
    localparam int MAXB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]    v_drv  = 2'b00;
    logic [1:0]    we_drv = 2'b00;
    logic [1:0]    lk_drv = 2'b00;
    logic [AW-1:0] a_drv [2];
    logic [DW-1:0] d_drv [2];

    logic [1:0]      req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, bank_wdata;
    logic [DW-1:0]   bank_rdata;
    logic            rsp_err, bank_en, bank_we;
    logic [AW-1:0]   bank_addr;

    always #5 clk = ~clk;

    cfg_reg_arbiter #(
        .ADDR_WIDTH (AW),
        .REG_WIDTH  (DW),
        .NUM_REGS   (NREGS),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (v_drv),
        .req_write  (we_drv),
        .req_lock   (lk_drv),
        .req_addr   ({a_drv[1], a_drv[0]}),
        .req_wdata  ({d_drv[1], d_drv[0]}),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bank_en    (bank_en),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata)
    );

    // Register bank with one cycle read latency; the read port shows noise
    // on cycles without a read so stale data cannot pass by accident.
    logic [DW-1:0] bank_mem [64] = '{default: '0};
    always @(posedge clk) begin
        if (bank_en && bank_we) bank_mem[bank_addr] <= bank_wdata;
        if (bank_en && !bank_we) bank_rdata <= bank_mem[bank_addr];
        else                     bank_rdata <= DW'($urandom);
    end

    // ---------------- scoreboard / reference model ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW-1:0] shadow [64] = '{default: '0};
    bit      m_rr, m_owner, m_lock;
    int      m_run;      // consecutive grants to the current owner
    int      m_age;      // cycles since the last accept (>=3: free)
    bit      t_who, t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_data;
    logic [1:0] acc;

    // DUT event logs used by the literal checks
    bit grant_log [$];
    int ready_cycs [$];
    int last_ready_cyc, last_bank_cyc, last_rsp_cyc, bank_cnt;
    int last_bank_addr, last_bank_we, last_bank_wdata;
    int last_rsp_idx, last_rsp_data, last_rsp_err;

    task automatic check(string name, int unsigned act, int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_owner = 0; m_lock = 0; m_run = 1; m_age = 3;
    endtask

    // Who wins given the current requests, by the arbitration rules.
    function automatic void pick(input logic [1:0] v, output bit w, output bit held);
        bit oth = !m_owner;
        bit lk  = m_lock && v[m_owner];
        held = 0;
        if (lk && !(v[oth] && m_run >= MAXB)) begin
            w = m_owner; held = 1;
        end else if (lk) begin
            w = oth;
        end else if (v == 2'b11) begin
            w = m_rr;
        end else begin
            w = v[1];
        end
    endfunction

    // One clock: compare at negedge, advance the model at posedge.
    task automatic step();
        bit w, held;
        logic [1:0] exp_ready, exp_rv;
        logic [DW-1:0] exp_rd;
        bit exp_err, exp_en;
        @(negedge clk);
        exp_ready = 0; exp_rv = 0; exp_rd = 0; exp_err = 0; exp_en = 0;
        if (m_age >= 3) begin
            if (|v_drv) begin
                pick(v_drv, w, held);
                exp_ready[w] = 1'b1;
            end
        end else if (m_age == 1) begin
            exp_en = int'(t_addr) < NREGS;
        end else begin
            exp_rv[t_who] = 1'b1;
            exp_err = int'(t_addr) >= NREGS;
            exp_rd  = (!t_we && !exp_err) ? shadow[t_addr] : '0;
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("bank_en",   32'(bank_en),   32'(exp_en));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check("rsp_err",   32'(rsp_err),   32'(exp_err));
        if (exp_en) begin
            check("bank_we",   32'(bank_we),   32'(t_we));
            check("bank_addr", 32'(bank_addr), 32'(t_addr));
            if (t_we) check("bank_wdata", 32'(bank_wdata), 32'(t_data));
        end
        if (req_ready != 0) begin
            last_ready_cyc = cyc;
            grant_log.push_back(req_ready[1]);
            ready_cycs.push_back(cyc);
        end
        if (bank_en) begin
            bank_cnt++;
            last_bank_cyc = cyc; last_bank_addr = 32'(bank_addr);
            last_bank_we = 32'(bank_we); last_bank_wdata = 32'(bank_wdata);
        end
        if (rsp_valid != 0) begin
            last_rsp_cyc = cyc; last_rsp_idx = 32'(rsp_valid[1]);
            last_rsp_data = 32'(rsp_rdata); last_rsp_err = 32'(rsp_err);
        end
        @(posedge clk);
        cyc++;
        acc = 2'b00;
        if (m_age >= 3 && |v_drv) begin
            pick(v_drv, w, held);
            acc[w] = 1'b1;
            if (held && v_drv[!w]) m_run++; else m_run = 1;
            if (!held) m_rr = !w;
            m_owner = w; m_lock = lk_drv[w];
            t_who = w; t_we = we_drv[w]; t_addr = a_drv[w]; t_data = d_drv[w];
            if (t_we && int'(t_addr) < NREGS) shadow[t_addr] = t_data;
            m_age = 1;
        end else if (m_age < 3) begin
            m_age++;
        end
        #1;
    endtask

    task automatic set_req(int i, bit we, bit lk, int a, int d);
        v_drv[i] = 1'b1; we_drv[i] = we; lk_drv[i] = lk;
        a_drv[i] = AW'(a); d_drv[i] = DW'(d);
    endtask

    task automatic wait_accept(int budget);
        int n = 0;
        do begin step(); n++; end while (acc == 0 && n < budget);
        if (acc == 0) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: no accept within %0d cycles", budget);
        end
    endtask

    task automatic single(int i, bit we, bit lk, int a, int d);
        set_req(i, we, lk, a, d);
        wait_accept(10);
        v_drv[i] = 1'b0;
        step(); step();
    endtask

    task automatic collect_grants(int n, int budget);
        int k = 0;
        grant_log.delete(); ready_cycs.delete();
        while (grant_log.size() < n && k < budget) begin step(); k++; end
        if (grant_log.size() < n) begin
            n_tests++; n_fail++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", grant_log.size(), n);
        end
    endtask

    task automatic new_req(int i);
        set_req(i, 1'($urandom), $urandom_range(0, 99) < 50,
                int'($urandom_range(0, 63)), int'($urandom_range(0, 255)));
    endtask

    initial begin
        int exp3 [4] = '{1, 0, 1, 0};
        int exp4 [6] = '{0, 0, 0, 0, 1, 0};
        a_drv[0] = '0; a_drv[1] = '0; d_drv[0] = '0; d_drv[1] = '0;
        model_reset();

        // Reset values with a request pending: everything must read 0
        v_drv = 2'b01;
        #12;
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 0);
        check("reset_rsp_err",   32'(rsp_err), 0);
        check("reset_bank", 32'({bank_en, bank_we, bank_addr, bank_wdata}), 0);
        v_drv = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;

        // Write 5 <- 0xA5 from req 0: ready T, bank write T+1, rsp T+2
        single(0, 1, 0, 5, 'hA5);
        check("wr_bank_latency", 32'(last_bank_cyc - last_ready_cyc), 1);
        check("wr_bank_addr", 32'(last_bank_addr), 5);
        check("wr_bank_we", 32'(last_bank_we), 1);
        check("wr_bank_wdata", 32'(last_bank_wdata), 'hA5);
        check("wr_rsp_latency", 32'(last_rsp_cyc - last_ready_cyc), 2);
        check("wr_rsp_owner", 32'(last_rsp_idx), 0);
        check("wr_rsp_err", 32'(last_rsp_err), 0);

        // Read it back
        single(0, 0, 0, 5, 0);
        check("rd_rdata", 32'(last_rsp_data), 'hA5);
        check("rd_rsp_latency", 32'(last_rsp_cyc - last_ready_cyc), 2);

        // Both requesting, no lock: the pointer now favours req 1
        set_req(0, 0, 0, 10, 0);
        set_req(1, 0, 0, 11, 0);
        collect_grants(4, 30);
        v_drv = 2'b00; step(); step();
        if (grant_log.size() >= 4) begin
            for (int k = 0; k < 4; k++) check("rr_order", 32'(grant_log[k]), 32'(exp3[k]));
            for (int k = 0; k < 3; k++) check("rr_spacing", 32'(ready_cycs[k+1] - ready_cycs[k]), 3);
        end

        // Burst lock: req 1 once to aim the pointer at req 0, then req 0
        // locks with req 1 waiting
        single(1, 0, 0, 12, 0);
        set_req(0, 0, 1, 13, 0);
        set_req(1, 0, 0, 14, 0);
        collect_grants(6, 40);
        v_drv = 2'b00; step(); step();
        if (grant_log.size() >= 6)
            for (int k = 0; k < 6; k++) check("burst_order", 32'(grant_log[k]), 32'(exp4[k]));

        // Range boundary (NUM_REGS = 60)
        single(1, 1, 0, 59, 'h5A);
        single(1, 0, 0, 59, 0);
        check("range_last_ok_data", 32'(last_rsp_data), 'h5A);
        check("range_last_ok_err", 32'(last_rsp_err), 0);
        bank_cnt = 0;
        single(1, 0, 0, 60, 0);
        check("oob_err", 32'(last_rsp_err), 1);
        check("oob_rdata", 32'(last_rsp_data), 0);
        single(0, 1, 0, 62, 'h3C);
        check("oob_wr_err", 32'(last_rsp_err), 1);
        check("oob_no_bank_en", 32'(bank_cnt), 0);

        // Reset in the middle of an access
        single(0, 0, 0, 3, 0);
        set_req(0, 0, 0, 7, 0);
        wait_accept(10);
        v_drv = 2'b00;
        #2;
        check("rst_pre_bank_en", 32'(bank_en), 1);
        rst = 1'b1;
        v_drv = 2'b11;
        a_drv[1] = AW'(8);
        #1;
        check("rst_bank_en", 32'(bank_en), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        check("rst_hold_ready", 32'(req_ready), 0);
        check("rst_hold_rsp_valid", 32'(rsp_valid), 0);
        rst = 1'b0;
        model_reset();
        grant_log.delete();
        wait_accept(5);
        if (grant_log.size() >= 1) check("rst_first_grant", 32'(grant_log[0]), 0);
        v_drv = 2'b00; step(); step();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    if ($urandom_range(0, 99) < 60) new_req(i);
                    else v_drv[i] = 1'b0;
                end else if (v_drv[i]) begin
                    if ($urandom_range(0, 99) < 4) v_drv[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 40) begin
                    new_req(i);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
